// File: rtl/led_pkg.sv
// Shared types, field layout and helpers for the status-LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_PWM   = 2'd2,
    LED_BLINK = 2'd3
  } led_mode_e;

  // wdata layout: {mode[1:0], duty[PWM_BITS-1:0]}
  localparam int MODE_W   = 2;
  localparam int DUTY_LSB = 0;

  function automatic int mode_lsb(input int pwm_bits);
    return DUTY_LSB + pwm_bits;
  endfunction

  function automatic int calc_pwm_div(input longint clk_freq, input longint pwm_hz,
                                      input int pwm_bits);
    return int'(clk_freq / (pwm_hz << pwm_bits));
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode register, double-buffered duty and the PWM/blink compare.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                we,
  input  logic [PWM_BITS+1:0] wdata,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                frame_start,
  input  logic                blink_phase,
  output logic                led_on
);

  localparam int MODE_LSB = mode_lsb(PWM_BITS);

  led_mode_e           mode_reg;
  logic [PWM_BITS-1:0] shadow_reg;
  logic [PWM_BITS-1:0] active_reg;
  logic                pwm_hit;

  // Active duty only moves at frame start; a write on that same edge lands in shadow only.
  always_ff @(posedge clk) begin
    if (srst) begin
      mode_reg   <= LED_OFF;
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      if (we) begin
        mode_reg   <= led_mode_e'(wdata[MODE_LSB +: MODE_W]);
        shadow_reg <= wdata[DUTY_LSB +: PWM_BITS];
      end
      if (frame_start) begin
        active_reg <= shadow_reg;
      end
    end
  end

  assign pwm_hit = (pwm_cnt < active_reg);

  always_comb begin
    led_on = 1'b0;
    case (mode_reg)
      LED_OFF:   led_on = 1'b0;
      LED_ON:    led_on = 1'b1;
      LED_PWM:   led_on = pwm_hit;
      LED_BLINK: led_on = pwm_hit & blink_phase;
      default:   led_on = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_driver.sv
// Status-LED driver: shared prescaler, PWM/blink/trap timing, per-channel compare and
// registered pin outputs with selectable polarity.
module led_driver
  import led_pkg::*;
#(
  parameter  int CHANNELS     = 5,
  parameter  int CLK_FREQ     = 48_000_000,
  parameter  int PWM_HZ       = 1_000,
  parameter  int PWM_BITS     = 8,
  parameter  int BLINK_FRAMES = 250,
  parameter  int ACTIVE_LOW   = 1,
  // One extra index bit on power-of-two builds so out-of-range writes can be expressed.
  localparam int CH_W         = $clog2(CHANNELS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [CH_W-1:0]     ch_i,
  input  logic [PWM_BITS+1:0] wdata_i,
  input  logic                trap_i,
  input  logic                trap_clr_i,
  output logic [CHANNELS-1:0] led_o,
  output logic                led_trap_o,
  output logic                frame_o
);

  localparam int   PWM_DIV = calc_pwm_div(CLK_FREQ, PWM_HZ, PWM_BITS);
  localparam int   DIV_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int   QUARTER = BLINK_FRAMES / 4;
  localparam int   BLINK_W = $clog2(BLINK_FRAMES);
  localparam int   TRAP_W  = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic POL     = (ACTIVE_LOW != 0);

  if (PWM_DIV < 1) begin : g_bad_div
    $error("led_driver: CLK_FREQ too low for PWM_HZ and PWM_BITS");
  end
  if ((BLINK_FRAMES < 4) || (BLINK_FRAMES % 4 != 0)) begin : g_bad_blink
    $error("led_driver: BLINK_FRAMES must be a multiple of 4 and >= 4");
  end

  logic [DIV_W-1:0]    div_cnt_reg;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                frame_start;
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic                blink_phase_reg;
  logic [TRAP_W-1:0]   trap_cnt_reg;
  logic                trap_phase_reg;
  logic                trap_latch_reg;
  logic [CHANNELS-1:0] raw_on;
  logic [CHANNELS-1:0] led_reg;
  logic                led_trap_reg;
  logic                frame_reg;

  assign tick        = (div_cnt_reg == DIV_W'(PWM_DIV - 1));
  assign frame_start = tick && (pwm_cnt_reg == '1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_reg     <= '0;
      pwm_cnt_reg     <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      trap_cnt_reg    <= '0;
      trap_phase_reg  <= 1'b0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick) begin
        pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
      if (frame_start) begin
        if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
        if (trap_cnt_reg == TRAP_W'(QUARTER - 1)) begin
          trap_cnt_reg   <= '0;
          trap_phase_reg <= ~trap_phase_reg;
        end else begin
          trap_cnt_reg <= trap_cnt_reg + 1'b1;
        end
      end
    end
  end

  // A new trap in the same cycle as a clear must not be lost, so set has priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trap_latch_reg <= 1'b0;
    end else if (trap_i) begin
      trap_latch_reg <= 1'b1;
    end else if (trap_clr_i) begin
      trap_latch_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic ch_we;
    assign ch_we = we_i && (ch_i < CH_W'(CHANNELS)) && (ch_i == CH_W'(gi));

    led_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_channel (
      .clk        (clk_i),
      .srst       (rst_i),
      .we         (ch_we),
      .wdata      (wdata_i),
      .pwm_cnt    (pwm_cnt_reg),
      .frame_start(frame_start),
      .blink_phase(blink_phase_reg),
      .led_on     (raw_on[gi])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_reg      <= {CHANNELS{POL}};
      led_trap_reg <= POL;
      frame_reg    <= 1'b0;
    end else begin
      led_reg      <= (trap_latch_reg ? {CHANNELS{trap_phase_reg}} : raw_on) ^ {CHANNELS{POL}};
      led_trap_reg <= trap_latch_reg ^ POL;
      frame_reg    <= frame_start;
    end
  end

  assign led_o      = led_reg;
  assign led_trap_o = led_trap_reg;
  assign frame_o    = frame_reg;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: per-frame low-cycle counts are predicted when
// stimulus is applied, queued, and compared once the frame has been observed.
module tb_led_driver;
  import led_pkg::*;

  localparam int CH    = 4;
  localparam int FRAME = 16;
  localparam int BF    = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          we_i;
  logic [2:0]    ch_i;
  logic [5:0]    wdata_i;
  logic          trap_i;
  logic          trap_clr_i;
  logic [CH-1:0] led_o;
  logic          led_trap_o;
  logic          frame_o;

  always #5 clk_i = ~clk_i;

  led_driver #(
    .CHANNELS    (CH),
    .CLK_FREQ    (16_000),
    .PWM_HZ      (1_000),
    .PWM_BITS    (4),
    .BLINK_FRAMES(BF),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (we_i),
    .ch_i      (ch_i),
    .wdata_i   (wdata_i),
    .trap_i    (trap_i),
    .trap_clr_i(trap_clr_i),
    .led_o     (led_o),
    .led_trap_o(led_trap_o),
    .frame_o   (frame_o)
  );

  typedef struct {
    string tag;
    int    ch;
    int    lows;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;
  int   frame_no;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge; frame_no counts frame_o pulses since reset.
  task automatic step();
    @(negedge clk_i);
    if (rst_i) frame_no = 0;
    else if (frame_o === 1'b1) frame_no++;
  endtask

  task automatic write(input int ch, input logic [1:0] mode, input int duty);
    we_i    = 1'b1;
    ch_i    = 3'(ch);
    wdata_i = {mode, 4'(duty)};
    step();
    we_i    = 1'b0;
    $display("write ch%0d mode %0d duty %0d", ch, mode, duty);
  endtask

  task automatic expect_all(input string tag, input int l0, input int l1, input int l2,
                            input int l3);
    int v[CH];
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    for (int c = 0; c < CH; c++) begin
      exp_t e;
      e.tag = tag; e.ch = c; e.lows = v[c];
      sb_q.push_back(e);
    end
  endtask

  function automatic int next_frame();
    return (frame_o === 1'b1) ? frame_no : frame_no + 1;
  endfunction

  function automatic int blink_lows(input int k);
    return (((k / BF) % 2) == 1) ? 15 : 0;
  endfunction

  function automatic int trap_lows(input int k);
    return ((k % 2) == 1) ? FRAME : 0;
  endfunction

  // Count low cycles per channel over one whole frame, optionally writing mid-frame.
  task automatic measure_frame(input bit wr_en, input int wr_at, input int wr_ch,
                               input logic [5:0] wr_data);
    int   lows[CH];
    int   guard;
    int   k;
    exp_t e;
    guard = 0;
    while (frame_o !== 1'b1 && guard < 3 * FRAME) begin
      step();
      guard++;
    end
    if (frame_o !== 1'b1) begin
      check("frame_timeout", 0, 1);
      sb_q.delete();
      return;
    end
    k = frame_no;
    foreach (lows[c]) lows[c] = 0;
    for (int i = 0; i < FRAME; i++) begin
      we_i    = wr_en && (i == wr_at);
      ch_i    = 3'(wr_ch);
      wdata_i = wr_data;
      step();
      for (int c = 0; c < CH; c++) if (led_o[c] === 1'b0) lows[c]++;
    end
    we_i = 1'b0;
    $display("frame %0d: low cycles ch0..3 = %0d %0d %0d %0d", k, lows[0], lows[1],
             lows[2], lows[3]);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s_f%0d_ch%0d", e.tag, k, e.ch), lows[e.ch], e.lows);
    end
  endtask

  initial begin
    int n;
    int k;
    rst_i = 1'b1; we_i = 1'b0; ch_i = '0; wdata_i = '0;
    trap_i = 1'b0; trap_clr_i = 1'b0;
    n_checks = 0; n_fail = 0; frame_no = 0;

    // Reset and first frame latency
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", led_o, 4'hF);
      check("rst_trap", led_trap_o, 1'b1);
      check("rst_frame", frame_o, 1'b0);
    end
    rst_i = 1'b0;
    step();
    check("post_rst_led", led_o, 4'hF);
    check("post_rst_trap", led_trap_o, 1'b1);
    check("post_rst_frame", frame_o, 1'b0);
    n = 1;
    while (frame_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("first_frame_latency", n, FRAME);

    // PWM duty
    write(1, LED_PWM, 4);
    expect_all("pwm4", 0, 4, 0, 0);
    measure_frame(1'b0, 0, 0, '0);
    write(1, LED_PWM, 0);
    expect_all("pwm0", 0, 0, 0, 0);
    measure_frame(1'b0, 0, 0, '0);
    write(1, LED_PWM, 15);
    expect_all("pwm15", 0, 15, 0, 0);
    measure_frame(1'b0, 0, 0, '0);
    write(1, LED_PWM, 4);
    expect_all("pwm4b", 0, 4, 0, 0);
    measure_frame(1'b0, 0, 0, '0);

    // Double-buffered duty: mid-frame and frame-start writes
    expect_all("midwr_old", 0, 4, 0, 0);
    measure_frame(1'b1, 6, 1, {LED_PWM, 4'd12});
    expect_all("midwr_new", 0, 12, 0, 0);
    measure_frame(1'b0, 0, 0, '0);
    expect_all("fswr_cur", 0, 12, 0, 0);
    measure_frame(1'b1, 15, 1, {LED_PWM, 4'd4});
    expect_all("fswr_hold", 0, 12, 0, 0);
    measure_frame(1'b0, 0, 0, '0);
    expect_all("fswr_new", 0, 4, 0, 0);
    measure_frame(1'b0, 0, 0, '0);

    // ON latency and blink
    we_i = 1'b1; ch_i = 3'd0; wdata_i = {LED_ON, 4'd0};
    step();
    we_i = 1'b0;
    check("on_lat_edge1", led_o[0], 1'b1);
    step();
    check("on_lat_edge2", led_o[0], 1'b0);
    write(2, LED_BLINK, 15);
    for (int i = 0; i < 2 * BF; i++) begin
      k = next_frame();
      expect_all("blink", FRAME, 4, blink_lows(k), 0);
      measure_frame(1'b0, 0, 0, '0);
    end

    // Trap
    trap_i = 1'b1;
    step();
    trap_i = 1'b0;
    step();
    check("trap_led_on", led_trap_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      k = next_frame();
      expect_all("trap", trap_lows(k), trap_lows(k), trap_lows(k), trap_lows(k));
      measure_frame(1'b0, 0, 0, '0);
    end
    trap_i = 1'b1; trap_clr_i = 1'b1;
    step();
    trap_i = 1'b0; trap_clr_i = 1'b0;
    step();
    check("trap_set_wins", led_trap_o, 1'b0);
    k = next_frame();
    expect_all("trap_held", trap_lows(k), trap_lows(k), trap_lows(k), trap_lows(k));
    measure_frame(1'b0, 0, 0, '0);
    trap_clr_i = 1'b1;
    step();
    trap_clr_i = 1'b0;
    step();
    check("trap_cleared", led_trap_o, 1'b1);
    k = next_frame();
    expect_all("resume", FRAME, 4, blink_lows(k), 0);
    measure_frame(1'b0, 0, 0, '0);

    // Out-of-range channel write is ignored
    write(5, LED_ON, 15);
    for (int i = 0; i < 3; i++) begin
      k = next_frame();
      expect_all("badch", FRAME, 4, blink_lows(k), 0);
      measure_frame(1'b0, 0, 0, '0);
    end

    // Reset mid-blink
    rst_i = 1'b1;
    step();
    check("midrst_led", led_o, 4'hF);
    check("midrst_trap", led_trap_o, 1'b1);
    check("midrst_frame", frame_o, 1'b0);
    rst_i = 1'b0;
    expect_all("after_rst", 0, 0, 0, 0);
    measure_frame(1'b0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
